// File: rtl/spi_master_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_master_arbiter_if : requester and SPI-driver bus of the arbiter |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface spi_master_arbiter_if #(
   parameter int N_REQ = 2,
   parameter int LEN_W = 4
);
   logic [N_REQ-1:0]       req_bi;
   logic [N_REQ*LEN_W-1:0] len_bi;
   logic [N_REQ*8-1:0]     tx_data_bi;
   logic [N_REQ-1:0]       gnt_bo;
   logic [N_REQ-1:0]       tx_ack_bo;
   logic [7:0]             rx_data_bo;
   logic [N_REQ-1:0]       rx_valid_bo;
   logic [N_REQ-1:0]       done_bo;
   logic                   drv_start_o;
   logic [7:0]             drv_data_bo;
   logic                   drv_ready_i;
   logic [7:0]             drv_data_bi;

   modport master (
      input  req_bi, len_bi, tx_data_bi, drv_ready_i, drv_data_bi,
      output gnt_bo, tx_ack_bo, rx_data_bo, rx_valid_bo, done_bo,
             drv_start_o, drv_data_bo
   );

   modport slave (
      output req_bi, len_bi, tx_data_bi, drv_ready_i, drv_data_bi,
      input  gnt_bo, tx_ack_bo, rx_data_bo, rx_valid_bo, done_bo,
             drv_start_o, drv_data_bo
   );
endinterface
`default_nettype wire

// File: rtl/spi_master_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_master_arbiter : round-robin sharing of one SPI master driver   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module spi_master_arbiter #(
   parameter int N_REQ   = 2,
   parameter int LEN_W   = 4,
   parameter int GAP_CYC = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   spi_master_arbiter_if.master bus
);
   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int GAP_W = $clog2(GAP_CYC + 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LOAD      = 3'd1;
   localparam logic [2:0] S_START     = 3'd2;
   localparam logic [2:0] S_WAIT_BUSY = 3'd3;
   localparam logic [2:0] S_WAIT_DONE = 3'd4;
   localparam logic [2:0] S_NEXT      = 3'd5;
   localparam logic [2:0] S_GAP       = 3'd6;

   logic [2:0]       state, state_nx;
   logic [N_REQ-1:0] gnt;
   logic [PTR_W-1:0] gnt_idx, ptr, sel_idx;
   logic             sel_found;
   logic [LEN_W-1:0] cnt;
   logic [7:0]       drv_data, rx_data;
   logic [2:0]       wd;
   logic [GAP_W-1:0] gap_cnt;

   // First requesting index at or after the pointer, wrapping around
   always_comb begin
      logic [PTR_W-1:0] cand;
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = PTR_W'((int'(ptr) + i) % N_REQ);
         if (!sel_found && bus.req_bi[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:      if (sel_found && bus.drv_ready_i) state_nx = S_LOAD;
         S_LOAD:      state_nx = S_START;
         S_START:     state_nx = S_WAIT_BUSY;
         S_WAIT_BUSY: begin
            if (!bus.drv_ready_i)  state_nx = S_WAIT_DONE;
            else if (wd == 3'd7)   state_nx = S_START;
         end
         S_WAIT_DONE: if (bus.drv_ready_i) state_nx = S_NEXT;
         S_NEXT:      state_nx = (cnt != '0) ? S_LOAD : S_GAP;
         S_GAP:       if (gap_cnt == GAP_LAST) state_nx = S_IDLE;
         default:     state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         gnt      <= '0;
         gnt_idx  <= '0;
         ptr      <= '0;
         cnt      <= '0;
         drv_data <= '0;
         rx_data  <= '0;
         wd       <= '0;
         gap_cnt  <= '0;
      end else begin
         wd <= 3'd0;
         case (state)
            S_IDLE: begin
               if (state_nx == S_LOAD) begin
                  gnt     <= N_REQ'(1) << sel_idx;
                  gnt_idx <= sel_idx;
                  cnt     <= bus.len_bi[int'(sel_idx)*LEN_W +: LEN_W];
               end
            end
            S_LOAD:      drv_data <= bus.tx_data_bi[int'(gnt_idx)*8 +: 8];
            // Counts idle-driver cycles after a start; wraps to 0 on re-issue
            S_WAIT_BUSY: if (bus.drv_ready_i) wd <= wd + 3'd1;
            S_WAIT_DONE: if (bus.drv_ready_i) rx_data <= bus.drv_data_bi;
            S_NEXT: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  gnt <= '0;
                  ptr <= (gnt_idx == PTR_LAST) ? '0 : gnt_idx + 1'b1;
               end
            end
            S_GAP:   gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 1'b1;
            default: ;
         endcase
      end
   end

   // Pulses are decoded from state and gated by the held grant
   always_comb begin
      bus.gnt_bo      = gnt;
      bus.drv_data_bo = drv_data;
      bus.rx_data_bo  = rx_data;
      bus.drv_start_o = (state == S_START);
      bus.tx_ack_bo   = (state == S_LOAD) ? gnt : '0;
      bus.rx_valid_bo = (state == S_NEXT) ? gnt : '0;
      bus.done_bo     = (state == S_NEXT && cnt == '0) ? gnt : '0;
   end
endmodule
`default_nettype wire

// File: tb/tb_spi_master_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_spi_master_arbiter : randomized bench with transaction-level model|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_spi_master_arbiter;
   localparam int N_REQ   = 2;
   localparam int LEN_W   = 4;
   localparam int GAP_CYC = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_master_arbiter_if #(.N_REQ(N_REQ), .LEN_W(LEN_W)) bus ();

   spi_master_arbiter #(.N_REQ(N_REQ), .LEN_W(LEN_W), .GAP_CYC(GAP_CYC)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model state shared by requester, driver and transaction monitor
   logic [7:0] cur_tx [N_REQ];
   logic [7:0] tx_plan [N_REQ][$];
   logic [7:0] exp_tx_q [$];
   logic [7:0] exp_rx_q [$];
   logic [7:0] resp_plan [$];
   logic [N_REQ-1:0] ack_pend = '0;
   int  mptr = 0, cur_g = 0, exp_len = 0, bytes_done = 0, starts_base = 0;
   int  n_starts = 0, n_done = 0, extra_starts = 0, stuck_left = 0;
   int  mcyc = 0, dcyc = 0, done_cyc = 0;
   bit  in_txn = 0, have_done = 0, held = 0;
   logic [7:0] last_rx = '0;

   function automatic int rr_pick(input logic [N_REQ-1:0] r, input int p);
      for (int i = 0; i < N_REQ; i++) begin
         int k;
         k = (p + i) % N_REQ;
         if (r[k]) return k;
      end
      return -1;
   endfunction

   function automatic logic [7:0] next_byte(input int k);
      if (tx_plan[k].size() > 0) return tx_plan[k].pop_front();
      return 8'($urandom);
   endfunction

   // Driver model: logs every start, optionally ignores some, answers after a random busy time
   initial begin
      int busy, last_start;
      bit prev_start, last_ignored;
      logic [7:0] resp;
      busy = 0; last_start = 0; prev_start = 0; last_ignored = 0; resp = '0;
      bus.drv_ready_i = 1'b1;
      bus.drv_data_bi = '0;
      forever begin
         @(negedge clk);
         dcyc++;
         if (!rst_n) begin
            bus.drv_ready_i = 1'b1;
            busy = 0; prev_start = 0; last_ignored = 0;
            continue;
         end
         if (bus.drv_start_o) begin
            check("start_width", 32'(prev_start), 0);
            n_starts++;
            if (last_ignored) check("wd_period", dcyc - last_start, 9);
            last_start = dcyc;
            if (stuck_left > 0) begin
               stuck_left--;
               last_ignored = 1;
            end else begin
               last_ignored = 0;
               if (exp_tx_q.size() == 0) check("tx_byte_missing", 1, 0);
               else check("tx_byte", bus.drv_data_bo, exp_tx_q.pop_front());
               bus.drv_ready_i = 1'b0;
               busy = $urandom_range(2, 5);
               resp = (resp_plan.size() > 0) ? resp_plan.pop_front() : 8'($urandom);
            end
         end else if (busy > 0) begin
            busy--;
            if (busy == 0) begin
               bus.drv_data_bi = resp;
               bus.drv_ready_i = 1'b1;
               exp_rx_q.push_back(resp);
            end
         end
         prev_start = bus.drv_start_o;
      end
   end

   // Requesters plus transaction-level checker
   initial begin
      int exp_g;
      for (int k = 0; k < N_REQ; k++) cur_tx[k] = 8'($urandom);
      for (int k = 0; k < N_REQ; k++) bus.tx_data_bi[k*8 +: 8] = cur_tx[k];
      forever begin
         @(posedge clk); #1;
         mcyc++;
         if (!rst_n) begin
            in_txn = 0; have_done = 0; mptr = 0; ack_pend = '0; extra_starts = 0;
            exp_tx_q.delete(); exp_rx_q.delete(); bytes_done = 0;
            continue;
         end
         check("gnt_onehot0", 32'($onehot0(bus.gnt_bo)), 1);
         check("pulse_gated", 32'((bus.tx_ack_bo | bus.rx_valid_bo | bus.done_bo) & ~bus.gnt_bo), 0);
         for (int k = 0; k < N_REQ; k++) if (ack_pend[k]) cur_tx[k] = next_byte(k);
         ack_pend = bus.tx_ack_bo;
         for (int k = 0; k < N_REQ; k++) if (bus.tx_ack_bo[k]) exp_tx_q.push_back(cur_tx[k]);
         for (int k = 0; k < N_REQ; k++) bus.tx_data_bi[k*8 +: 8] = cur_tx[k];
         if (!in_txn && bus.req_bi == '0) held = 0;

         if (!in_txn && bus.gnt_bo != '0) begin
            exp_g = rr_pick(bus.req_bi, mptr);
            if (exp_g < 0) check("grant_unexp", 32'(bus.gnt_bo), 0);
            else begin
               check("grant", 32'(bus.gnt_bo), 32'(1) << exp_g);
               cur_g = exp_g; in_txn = 1; bytes_done = 0; starts_base = n_starts;
               exp_len = int'(bus.len_bi[exp_g*LEN_W +: LEN_W]) + 1;
               if (have_done) begin
                  if (held) check("gap_exact", mcyc - done_cyc, GAP_CYC + 2);
                  else      check("gap_min", 32'((mcyc - done_cyc) >= GAP_CYC + 2), 1);
               end
            end
         end

         if (bus.rx_valid_bo != '0) begin
            if (!in_txn) check("rx_stray", 32'(bus.rx_valid_bo), 0);
            else begin
               check("rx_valid", 32'(bus.rx_valid_bo), 32'(1) << cur_g);
               if (exp_rx_q.size() == 0) check("rx_nodata", 1, 0);
               else check("rx_data", bus.rx_data_bo, exp_rx_q.pop_front());
               last_rx = bus.rx_data_bo;
               bytes_done++;
               if (bytes_done == exp_len) begin
                  check("done", 32'(bus.done_bo), 32'(1) << cur_g);
                  check("starts", n_starts - starts_base, exp_len + extra_starts);
                  extra_starts = 0; in_txn = 0; have_done = 1; done_cyc = mcyc;
                  mptr = (cur_g + 1) % N_REQ;
                  held = (bus.req_bi != '0);
                  n_done++;
               end else if (bus.done_bo != '0) check("done_early", 32'(bus.done_bo), 0);
            end
         end else if (bus.done_bo != '0) check("done_stray", 32'(bus.done_bo), 0);
      end
   end

   task automatic set_len(input int k, input int v);
      bus.len_bi[k*LEN_W +: LEN_W] = LEN_W'(v);
   endtask

   task automatic wait_done(input int target, input int budget);
      int c;
      c = 0;
      while (n_done < target && c < budget) begin
         @(negedge clk);
         c++;
      end
      check("done_timeout", 32'(n_done >= target), 1);
   endtask

   task automatic check_all_zero(input string tag);
      check(tag, {bus.gnt_bo, bus.tx_ack_bo, bus.rx_valid_bo, bus.done_bo,
                  bus.drv_start_o, bus.drv_data_bo, bus.rx_data_bo}, 0);
   endtask

   initial begin
      int c, hit;
      bus.req_bi = '0;
      bus.len_bi = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset_outputs");
      rst_n = 1'b1;

      // Single byte
      @(negedge clk);
      cur_tx[0] = 8'hA5; resp_plan.push_back(8'h3C); set_len(0, 0);
      @(negedge clk);
      bus.req_bi = 2'b01;
      wait_done(1, 200);
      bus.req_bi = '0;
      check("single_rx", last_rx, 8'h3C);
      @(negedge clk);
      check("single_gnt_clear", 32'(bus.gnt_bo), 0);

      // Multi-byte, request held for a second transaction to measure the gap
      cur_tx[0] = 8'h11;
      tx_plan[0].push_back(8'h22); tx_plan[0].push_back(8'h33); tx_plan[0].push_back(8'h44);
      set_len(0, 3);
      @(negedge clk);
      bus.req_bi = 2'b01;
      wait_done(3, 600);
      bus.req_bi = '0;

      // Contention: both held, two bytes each
      set_len(0, 1); set_len(1, 1);
      bus.req_bi = 2'b11;
      wait_done(7, 800);
      bus.req_bi = '0;

      // Early drop after first tx_ack
      repeat (GAP_CYC + 3) @(negedge clk);
      set_len(1, 2);
      bus.req_bi = 2'b10;
      c = 0;
      while (!bus.tx_ack_bo[1] && c < 100) begin @(negedge clk); c++; end
      check("early_ack_seen", 32'(bus.tx_ack_bo[1]), 1);
      @(negedge clk);
      bus.req_bi = '0;
      wait_done(8, 300);

      // Watchdog: driver ignores two starts
      stuck_left = 2; extra_starts = 2; set_len(0, 0);
      bus.req_bi = 2'b01;
      wait_done(9, 400);
      bus.req_bi = '0;

      // Reset during WAIT_DONE of byte 2 of requester 1
      set_len(0, 0);
      bus.req_bi = 2'b01;
      wait_done(10, 200);
      bus.req_bi = '0;
      set_len(1, 2);
      bus.req_bi = 2'b10;
      c = 0; hit = 0;
      while (hit < 2 && c < 300) begin
         @(posedge clk); #2;
         c++;
         if (in_txn && bytes_done == 1 && !bus.drv_ready_i && !bus.drv_start_o) hit++;
         else hit = 0;
      end
      check("reach_wait_done", hit, 2);
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset_outputs");
      bus.req_bi = 2'b11; set_len(0, 0); set_len(1, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      c = 0;
      while (bus.gnt_bo == '0 && c < 50) begin @(negedge clk); c++; end
      check("post_reset_grant", 32'(bus.gnt_bo), 1);
      wait_done(11, 200);
      bus.req_bi = '0;

      // Randomized traffic; len changed mid-transaction to confirm single sampling
      for (int it = 0; it < 24; it++) begin
         for (int k = 0; k < N_REQ; k++) set_len(k, $urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) begin stuck_left = 1; extra_starts = 1; end
         bus.req_bi = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
         c = 0;
         while (!in_txn && c < 100) begin @(negedge clk); c++; end
         for (int k = 0; k < N_REQ; k++) set_len(k, $urandom_range(0, 15));
         wait_done(12 + it, 600);
         if ($urandom_range(0, 2) == 0) bus.req_bi = '0;
      end
      bus.req_bi = '0;
      repeat (GAP_CYC + 6) @(negedge clk);
      check("final_idle", 32'(bus.gnt_bo), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
